// File: rtl/timer0_unit.sv
// TMR0 timer/counter with OPTION register and 8-bit prescaler for a PIC16C5x-style core.
// Optional T0IF overflow flag: define TIMER0_T0IF_EN to add t0ifClear/t0ifOut.
module timer0_unit #(
  parameter int SYNC_STAGES   = 2,
  parameter int INHIBIT_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instrTick,
  input  logic       optionWrite,
  input  logic [5:0] optionIn,
  input  logic       tmr0Write,
  input  logic [7:0] tmr0DataIn,
  input  logic       t0cki,
`ifdef TIMER0_T0IF_EN
  input  logic       t0ifClear,
  output logic       t0ifOut,
`endif
  output logic [7:0] tmr0Out,
  output logic [5:0] optionOut,
  output logic       overflowPulse
);

  localparam int INH_W = (INHIBIT_TICKS < 1) ? 1 : $clog2(INHIBIT_TICKS + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   ext_evt_q, ext_evt_d;
  logic [5:0]             opt_q, opt_d;
  logic [7:0]             presc_q, presc_d;
  logic [7:0]             tmr_q, tmr_d;
  logic [INH_W-1:0]       inh_q, inh_d;
  logic                   ovf_q, ovf_d;

  logic       sync_out;
  logic       t0cs, t0se, psa;
  logic [2:0] ps;
  logic [7:0] ps_mask;
  logic       evt, count_en, inc;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign t0cs     = opt_q[5];
  assign t0se     = opt_q[4];
  assign psa      = opt_q[3];
  assign ps       = opt_q[2:0];
  // Low PS+1 bits set; PS=7 shifts everything out and yields 0xFF.
  assign ps_mask  = ~(8'hFF << (4'(ps) + 4'd1));

  always_comb begin
    ext_evt_d = t0se ? (prev_q & ~sync_out) : (sync_out & ~prev_q);
    evt       = t0cs ? ext_evt_q : instrTick;
    count_en  = evt & (inh_q == '0) & ~tmr0Write;
    presc_d   = presc_q;
    inc       = 1'b0;
    if (psa) begin
      inc = count_en;
    end else if (count_en) begin
      presc_d = presc_q + 8'd1;
      inc     = ((presc_q & ps_mask) == ps_mask);
    end
    if (tmr0Write || optionWrite || psa) begin
      presc_d = 8'd0;
    end

    tmr_d = tmr_q;
    if (tmr0Write) begin
      tmr_d = tmr0DataIn;
    end else if (inc) begin
      tmr_d = tmr_q + 8'd1;
    end
    ovf_d = inc & (tmr_q == 8'hFF);

    // The write cycle itself never counts towards the inhibit window.
    inh_d = inh_q;
    if (tmr0Write) begin
      inh_d = INH_W'(INHIBIT_TICKS);
    end else if (instrTick && (inh_q != '0)) begin
      inh_d = inh_q - 1'b1;
    end

    opt_d = optionWrite ? optionIn : opt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      prev_q    <= 1'b0;
      ext_evt_q <= 1'b0;
      opt_q     <= 6'b111111;
      presc_q   <= 8'd0;
      tmr_q     <= 8'd0;
      inh_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], t0cki};
      prev_q    <= sync_out;
      ext_evt_q <= ext_evt_d;
      opt_q     <= opt_d;
      presc_q   <= presc_d;
      tmr_q     <= tmr_d;
      inh_q     <= inh_d;
      ovf_q     <= ovf_d;
    end
  end

`ifdef TIMER0_T0IF_EN
  logic t0if_q;

  // Set has priority over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t0if_q <= 1'b0;
    end else if (ovf_d) begin
      t0if_q <= 1'b1;
    end else if (t0ifClear) begin
      t0if_q <= 1'b0;
    end
  end

  assign t0ifOut = t0if_q;
`endif

  assign tmr0Out       = tmr_q;
  assign optionOut     = opt_q;
  assign overflowPulse = ovf_q;

endmodule
